bcd_seq_conv: RTL and testbench

- Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.
- Sits between the 8-bit adder/subtractor result ({Cout,S}, 9 bits) and the display digit multiplexer / BCD-to-7-segment decoder.
- Replaces the combinational converter with a registered, handshaked stage.
- Also provides a leading-zero blanking mask and an overflow flag for the display stage.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_add3.sv | 13 +
 rtl/bcd_seq_conv.sv | 125 ++++++++++++
 tb/tb_bcd_seq_conv.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Nibble code the 7-segment decoder renders as a blank digit.
  localparam logic [3:0] BLANK_CODE = 4'd11;

  // 10**n, used to derive the largest value DIGITS decimal digits can show.
  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a nibble of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  // No carry out of the nibble; values above 9 only occur on overflowed inputs.
  always_comb begin
    q_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
  end

endmodule

// File: rtl/bcd_seq_conv.sv
// Registered binary-to-BCD converter, one input bit per clock (shift-add-3).
// Results, leading-zero mask and overflow flag only change on the done pulse,
// so the display stage never sees a half-converted value.
module bcd_seq_conv
  import bcd_pkg::*;
#(
  parameter int WIDTH   = 9,
  parameter int DIGITS  = 3,
  parameter int OVF_MAX = pow10(DIGITS) - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     lz_mask,
  output logic                  ovf
);

  localparam int          SRW     = 4*DIGITS + WIDTH;
  localparam int          CW      = $clog2(WIDTH + 1);
  localparam logic [31:0] OVF_LIM = 32'(OVF_MAX);
  // Reset mask: every digit except the units digit blanked.
  localparam logic [DIGITS-1:0] LZ_RST = ~DIGITS'(1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SRW-1:0]          sr_q, sr_d;
  logic                    ovfp_q, ovfp_d;

  logic                    done_q;
  logic [4*DIGITS-1:0]     bcd_q;
  logic [DIGITS-1:0]       lz_q, lz_d;
  logic                    ovf_q;

  logic [DIGITS-1:0][3:0]  nib_q, nib_c, res;
  logic                    blank;

  // BCD half of the shift register, viewed as digits (k=0 is units).
  assign nib_q = sr_q[SRW-1 -: 4*DIGITS];

  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i (nib_q[k]),
      .q_o (nib_c[k])
    );
  end

  // Sequencer state, bit counter, shift register and pending overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      ovfp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      ovfp_q  <= ovfp_d;
    end
  end

  // Next-state logic: capture on start, WIDTH correct-and-shift steps, one DONE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    ovfp_d  = ovfp_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = SRW'(bin);
          cnt_d   = CW'(WIDTH);
          ovfp_d  = (32'(bin) > OVF_LIM);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d  = {nib_c, sr_q[WIDTH-1:0]} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Final digits (saturated to all nines on overflow) and leading-zero scan from the MSD.
  always_comb begin
    res   = ovfp_q ? {DIGITS{4'd9}} : nib_q;
    lz_d  = '0;
    blank = 1'b1;
    for (int k = DIGITS-1; k >= 1; k--) begin
      blank   = blank && (res[k] == 4'd0);
      lz_d[k] = blank;
    end
  end

  // Display-facing registers: updated only when leaving DONE, together with the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      bcd_q  <= '0;
      lz_q   <= LZ_RST;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        bcd_q <= res;
        lz_q  <= lz_d;
        ovf_q <= ovfp_q;
      end
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign bcd     = bcd_q;
  assign lz_mask = lz_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Bench for bcd_seq_conv: default 9-bit/3-digit instance plus a 10-bit one for overflow.
module tb_bcd_seq_conv;

  typedef struct {
    logic [11:0] bcd;
    logic [2:0]  lz;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start10;
  logic [8:0]  bin;
  logic [9:0]  bin10;
  logic        busy, done, ovf, busy10, done10, ovf10;
  logic [11:0] bcd, bcd10;
  logic [2:0]  lz, lz10;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_n = 0;
  exp_t q[$];
  exp_t q10[$];

  bcd_seq_conv dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin), .busy(busy), .done(done),
    .bcd(bcd), .lz_mask(lz), .ovf(ovf)
  );

  bcd_seq_conv #(.WIDTH(10), .DIGITS(3)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .bin(bin10), .busy(busy10), .done(done10),
    .bcd(bcd10), .lz_mask(lz10), .ovf(ovf10)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Independent reference: decimal digits by division, saturate above 999.
  function automatic exp_t model(input int v);
    exp_t e;
    logic [3:0] d0, d1, d2;
    if (v > 999) begin
      e.bcd = 12'h999; e.lz = 3'b000; e.ovf = 1'b1;
    end else begin
      d0 = 4'(v % 10); d1 = 4'((v / 10) % 10); d2 = 4'(v / 100);
      e.bcd = {d2, d1, d0};
      e.lz  = {d2 == 4'd0, (d2 == 4'd0) && (d1 == 4'd0), 1'b0};
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard: pop an expectation on every done pulse and compare.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++; $display("FAIL unexpected_done: got bcd=%h, required no done", bcd);
      end else begin
        e = q.pop_front();
        if (bcd !== e.bcd) begin n_err++; $display("FAIL bcd: got %h required %h", bcd, e.bcd); end
        n_cmp++;
        if (lz !== e.lz) begin n_err++; $display("FAIL lz_mask: got %b required %b", lz, e.lz); end
        n_cmp++;
        if (ovf !== e.ovf) begin n_err++; $display("FAIL ovf: got %b required %b", ovf, e.ovf); end
      end
    end
    if (done10) begin
      n_cmp++;
      if (q10.size() == 0) begin
        n_err++; $display("FAIL unexpected_done10: got bcd=%h, required no done", bcd10);
      end else begin
        e = q10.pop_front();
        if (bcd10 !== e.bcd) begin n_err++; $display("FAIL bcd10: got %h required %h", bcd10, e.bcd); end
        n_cmp++;
        if (lz10 !== e.lz) begin n_err++; $display("FAIL lz_mask10: got %b required %b", lz10, e.lz); end
        n_cmp++;
        if (ovf10 !== e.ovf) begin n_err++; $display("FAIL ovf10: got %b required %b", ovf10, e.ovf); end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic start_conv(input bit w, input int v);
    if (w) begin bin10 = 10'(v); start10 = 1'b1; q10.push_back(model(v)); end
    else   begin bin   = 9'(v);  start   = 1'b1; q.push_back(model(v));   end
  endtask

  // Waits for done; lat counts cycles from the accepting edge, bcyc counts busy cycles.
  task automatic wait_done(input bit w, input bit keep, output int lat, output int bcyc);
    lat = -1; bcyc = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (i == 1 && !keep) begin start = 1'b0; start10 = 1'b0; end
      if (w ? busy10 : busy) bcyc++;
      if (w ? done10 : done) begin lat = i - 1; return; end
    end
    n_cmp++; n_err++;
    $display("FAIL done_timeout: got no done in 40 cycles, required done");
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start10 = 1'b0; bin = '0; bin10 = '0;
    repeat (3) cyc();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b required 0", done); end
    n_cmp++; if (bcd !== 12'h000) begin n_err++; $display("FAIL rst_bcd: got %h required 000", bcd); end
    n_cmp++; if (lz !== 3'b110) begin n_err++; $display("FAIL rst_lz: got %b required 110", lz); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b required 0", ovf); end
    n_cmp++; if (lz10 !== 3'b110) begin n_err++; $display("FAIL rst_lz10: got %b required 110", lz10); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_zero();
    int lat, bc;
    start_conv(0, 0);
    wait_done(0, 0, lat, bc);
    n_cmp++; if (lat !== 10) begin n_err++; $display("FAIL zero_latency: got %0d required 10", lat); end
  endtask

  task automatic test_max_sum();
    int lat, bc;
    cyc();
    start_conv(0, 510);
    wait_done(0, 0, lat, bc);
    n_cmp++; if (bc !== 10) begin n_err++; $display("FAIL busy_cycles: got %0d required 10", bc); end
    repeat (3) cyc();
    n_cmp++; if (bcd !== 12'h510) begin n_err++; $display("FAIL hold_bcd: got %h required 510", bcd); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat, bc, t1, t2;
    start_conv(0, 9);
    wait_done(0, 1, lat, bc);
    t1 = cyc_n;
    start_conv(0, 42);
    // Previous result must still be on the outputs while the next one converts.
    cyc();
    start = 1'b0;
    n_cmp++; if (bcd !== 12'h009) begin n_err++; $display("FAIL b2b_hold: got %h required 009", bcd); end
    wait_done(0, 0, lat, bc);
    t2 = cyc_n;
    n_cmp++; if (t2 - t1 !== 11) begin n_err++; $display("FAIL b2b_spacing: got %0d required 11", t2 - t1); end
  endtask

  task automatic test_ignore_busy();
    int ndone;
    ndone = 0;
    cyc();
    start_conv(0, 123);
    for (int i = 1; i <= 30; i++) begin
      cyc();
      case (i)
        1, 4, 11: start = 1'b0;
        3, 10: begin start = 1'b1; bin = 9'd7; end
        default: ;
      endcase
      if (done) ndone++;
    end
    n_cmp++; if (ndone !== 1) begin n_err++; $display("FAIL ignore_done_count: got %0d required 1", ndone); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_busy: got %b required 0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, ndone;
    ndone = 0;
    start_conv(0, 300);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    q.delete();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b required 0", busy); end
    n_cmp++; if (bcd !== 12'h000) begin n_err++; $display("FAIL mid_rst_bcd: got %h required 000", bcd); end
    n_cmp++; if (lz !== 3'b110) begin n_err++; $display("FAIL mid_rst_lz: got %b required 110", lz); end
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (done) ndone++;
    end
    n_cmp++; if (ndone !== 0) begin n_err++; $display("FAIL mid_rst_done: got %0d required 0", ndone); end
    start_conv(0, 77);
    wait_done(0, 0, lat, bc);
  endtask

  task automatic test_overflow();
    int lat, bc;
    cyc();
    start_conv(1, 1023);
    wait_done(1, 0, lat, bc);
    n_cmp++; if (lat !== 11) begin n_err++; $display("FAIL w10_latency: got %0d required 11", lat); end
    cyc();
    start_conv(1, 999);
    wait_done(1, 0, lat, bc);
    cyc();
    start_conv(1, 1000);
    wait_done(1, 0, lat, bc);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max_sum();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_overflow();
    repeat (3) cyc();
    n_cmp++; if (q.size() !== 0) begin n_err++; $display("FAIL sb_leftover: got %0d required 0", q.size()); end
    n_cmp++; if (q10.size() !== 0) begin n_err++; $display("FAIL sb10_leftover: got %0d required 0", q10.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
